mdio_slave: RTL and testbench

- Clause-22 MDIO serial slave front-end for the PHY management register block.
- Samples MDC/MDIO in the system clock domain and parses management frames.
- Turns each frame addressed to this PHY into one Wishbone classic cycle on the register block's bus.
- Drives MDIO during read turnaround/data only when the register block acks.

---
 rtl/mdio_slave_pkg.sv | 22 ++
 rtl/mdio_sync.sv | 25 ++
 rtl/mdio_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_mdio_slave.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mdio_slave_pkg.sv
// Shared constants and FSM encoding for the Clause-22 MDIO slave front-end.
package mdio_slave_pkg;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST       = 2'b01;

  localparam logic [4:0] OP_LEN    = 5'd2;
  localparam logic [4:0] PHYAD_LEN = 5'd5;
  localparam logic [4:0] REGAD_LEN = 5'd5;
  localparam logic [4:0] TA_LEN    = 5'd2;
  localparam logic [4:0] DATA_LEN  = 5'd16;

  typedef enum logic [2:0] {
    S_PREAMBLE = 3'd0,
    S_ST       = 3'd1,
    S_OP       = 3'd2,
    S_PHYAD    = 3'd3,
    S_REGAD    = 3'd4,
    S_TA       = 3'd5,
    S_DATA     = 3'd6
  } state_e;
endpackage

// File: rtl/mdio_sync.sv
// Two-flop synchronisers for MDC/MDIO into clk, plus MDC rising-edge detect.
module mdio_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic rise_o,
  output logic bit_o
);
  logic [2:0] mdc_q;
  logic [1:0] mdio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_q  <= '0;
      mdio_q <= '0;
    end else begin
      mdc_q  <= {mdc_q[1:0], mdc_i};
      mdio_q <= {mdio_q[0], mdio_i};
    end
  end

  assign rise_o = mdc_q[1] & ~mdc_q[2];
  assign bit_o  = mdio_q[1];
endmodule

// File: rtl/mdio_slave.sv
// MDIO Clause-22 slave: parses management frames and issues one Wishbone
// classic cycle per addressed frame; drives read data back onto MDIO.
module mdio_slave
  import mdio_slave_pkg::*;
#(
  parameter logic [4:0] PHYAD        = 5'd0,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [4:0]  addr,
  output logic [15:0] data_write,
  input  logic        ack,
  input  logic        err,
  input  logic [15:0] data_read
);
  localparam logic [5:0] PRE_LEN6 = 6'(PREAMBLE_LEN);

  logic rise, bit_s;

  mdio_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .mdc_i  (mdc),
    .mdio_i (mdio_i),
    .rise_o (rise),
    .bit_o  (bit_s)
  );

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  pre_q, pre_d;
  logic [1:0]  op_q, op_d;
  logic        sel_q, sel_d;
  logic [14:0] sh_q;
  logic [4:0]  regad_q;
  logic [15:0] rdata_q, out_q;
  logic        cyc_q, we_q, cap_q, rvalid_q, oe_q, mo_q;
  logic [4:0]  addr_q;
  logic [15:0] wdata_q;
  logic        reg_done, rd_start, wr_start, ta0, ta1, dshift, dlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PREAMBLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      op_q    <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    op_d     = op_q;
    sel_d    = sel_q;
    reg_done = 1'b0;
    wr_start = 1'b0;
    ta0      = 1'b0;
    ta1      = 1'b0;
    dshift   = 1'b0;
    dlast    = 1'b0;
    if (rise) begin
      unique case (state_q)
        S_PREAMBLE: begin
          if (bit_s) begin
            pre_d = (pre_q == 6'h3f) ? pre_q : pre_q + 6'd1;
          end else begin
            pre_d = '0;
            if (pre_q >= PRE_LEN6) state_d = S_ST;
          end
        end
        S_ST: begin
          if ({sh_q[0], bit_s} == ST) begin
            state_d = S_OP;
            cnt_d   = OP_LEN - 5'd1;
          end else begin
            state_d = S_PREAMBLE;
          end
        end
        S_OP: begin
          if (cnt_q == '0) begin
            if ({sh_q[0], bit_s} == OP_READ || {sh_q[0], bit_s} == OP_WRITE) begin
              op_d    = {sh_q[0], bit_s};
              state_d = S_PHYAD;
              cnt_d   = PHYAD_LEN - 5'd1;
            end else begin
              state_d = S_PREAMBLE;
            end
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_PHYAD: begin
          if (cnt_q == '0) begin
            sel_d   = ({sh_q[3:0], bit_s} == PHYAD);
            state_d = S_REGAD;
            cnt_d   = REGAD_LEN - 5'd1;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_REGAD: begin
          if (cnt_q == '0) begin
            reg_done = 1'b1;
            state_d  = S_TA;
            cnt_d    = TA_LEN - 5'd1;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_TA: begin
          if (cnt_q == '0) begin
            ta1     = 1'b1;
            state_d = S_DATA;
            cnt_d   = DATA_LEN - 5'd1;
          end else begin
            ta0   = 1'b1;
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            dlast    = 1'b1;
            wr_start = sel_q && (op_q == OP_WRITE);
            state_d  = S_PREAMBLE;
          end else begin
            dshift = 1'b1;
            cnt_d  = cnt_q - 5'd1;
          end
        end
        default: state_d = S_PREAMBLE;
      endcase
    end
  end

  assign rd_start = reg_done && sel_q && (op_q == OP_READ);

  // Datapath shift/capture registers carry no reset; control gates their use.
  always_ff @(posedge clk) begin
    if (rise) sh_q <= {sh_q[13:0], bit_s};
    if (reg_done) regad_q <= {sh_q[3:0], bit_s};
    if (cap_q) rdata_q <= data_read;
    if (ta1) out_q <= {rdata_q[14:0], 1'b0};
    else if (dshift) out_q <= {out_q[14:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cap_q    <= 1'b0;
      rvalid_q <= 1'b0;
      oe_q     <= 1'b0;
      mo_q     <= 1'b0;
    end else begin
      if (cap_q) begin
        rvalid_q <= 1'b1;
        cap_q    <= 1'b0;
      end
      if (rd_start) begin
        cyc_q    <= 1'b1;
        we_q     <= 1'b0;
        addr_q   <= {sh_q[3:0], bit_s};
        rvalid_q <= 1'b0;
        cap_q    <= 1'b0;
      end else if (wr_start) begin
        cyc_q   <= 1'b1;
        we_q    <= 1'b1;
        addr_q  <= regad_q;
        wdata_q <= {sh_q, bit_s};
      end else if (cyc_q && (ack || err)) begin
        // A response coinciding with the TA0 abort takes precedence.
        cyc_q <= 1'b0;
        we_q  <= 1'b0;
        if (!we_q && ack) cap_q <= 1'b1;
        if (!we_q && err) rvalid_q <= 1'b0;
      end else if (ta0 && cyc_q && !we_q) begin
        cyc_q    <= 1'b0;
        rvalid_q <= 1'b0;
      end

      if (ta0) begin
        oe_q <= sel_q && (op_q == OP_READ) &&
                (rvalid_q || cap_q || (cyc_q && !we_q && ack));
        mo_q <= 1'b0;
      end else if (ta1 && oe_q) begin
        mo_q <= rdata_q[15];
      end else if (dshift && oe_q) begin
        mo_q <= out_q[15];
      end else if (dlast) begin
        oe_q <= 1'b0;
        mo_q <= 1'b0;
      end
    end
  end

  assign cyc        = cyc_q;
  assign stb        = cyc_q;
  assign we         = we_q;
  assign addr       = addr_q;
  assign data_write = wdata_q;
  assign mdio_oe    = oe_q;
  assign mdio_o     = mo_q;
endmodule

// File: tb/tb_mdio_slave.sv
// Directed bench for mdio_slave (PHYAD=3, PREAMBLE_LEN=32).
module tb_mdio_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdc = 1'b0;
  logic        mdio_m = 1'b1;
  logic        mdio_o, mdio_oe, cyc, stb, we, ack, err;
  logic [4:0]  addr;
  logic [15:0] data_write;
  logic [15:0] data_read = 16'h7809;
  int          resp_mode = 0;  // 0 ack, 1 err, 2 no response

  always #5 clk = ~clk;

  mdio_slave #(.PHYAD(5'd3), .PREAMBLE_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_i(mdio_m),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .cyc(cyc), .stb(stb), .we(we),
    .addr(addr), .data_write(data_write), .ack(ack), .err(err),
    .data_read(data_read)
  );

  assign ack = cyc && stb && (resp_mode == 0);
  assign err = cyc && stb && (resp_mode == 1);

  int          n_cyc = 0, cyc_clks = 0, oe_clks = 0;
  logic        last_we;
  logic [4:0]  last_addr;
  logic [15:0] last_dw;

  always @(posedge clk) begin
    if (cyc) cyc_clks++;
    if (mdio_oe) oe_clks++;
    if (cyc && stb && (ack || err)) begin
      n_cyc++;
      last_we   = we;
      last_addr = addr;
      last_dw   = data_write;
    end
  end

  int   errs = 0, checks = 0;
  logic obs_o[32], obs_oe[32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic mdc_bit(input logic b, input int k);
    mdio_m = b;
    repeat (8) @(negedge clk);
    if (k >= 0 && k < 32) begin
      obs_o[k]  = mdio_o;
      obs_oe[k] = mdio_oe;
    end
    mdc = 1'b1;
    repeat (8) @(negedge clk);
    mdc = 1'b0;
  endtask

  // nbits: how many bits after the preamble to send (32 = whole frame)
  task automatic send_frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] rg, input logic [15:0] wd, input int nbits);
    logic [31:0] f;
    if (op == 2'b01) f = {2'b01, op, phy, rg, 2'b10, wd};
    else             f = {2'b01, op, phy, rg, 2'b11, 16'hffff};
    for (int k = 0; k < 32; k++) begin
      obs_o[k]  = 1'bx;
      obs_oe[k] = 1'bx;
    end
    for (int i = 0; i < npre; i++) mdc_bit(1'b1, -1);
    for (int k = 0; k < nbits; k++) mdc_bit(f[31-k], k);
    mdio_m = 1'b1;
  endtask

  function automatic logic [15:0] rd_word();
    logic [15:0] w;
    for (int j = 0; j < 16; j++) w[15-j] = obs_o[16+j];
    return w;
  endfunction

  function automatic logic [16:0] oe_mask();
    logic [16:0] m;
    for (int j = 0; j < 17; j++) m[16-j] = obs_oe[15+j];
    return m;
  endfunction

  int c0, o0, k0;

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_stb_we", {30'd0, stb, we}, 32'd0);
    chk("rst_oe", {31'd0, mdio_oe}, 32'd0);
    chk("rst_mdio_o", {31'd0, mdio_o}, 32'd0);
    chk("rst_addr", {27'd0, addr}, 32'd0);
    chk("rst_wdata", {16'd0, data_write}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Read PHY 3 REG 1, acked with 7809
    c0 = n_cyc;
    send_frame(32, 2'b10, 5'd3, 5'd1, 16'h0, 32);
    chk("rd_ncyc", n_cyc - c0, 1);
    chk("rd_we", {31'd0, last_we}, 32'd0);
    chk("rd_addr", {27'd0, last_addr}, 32'd1);
    chk("rd_oe_before_ta0", {31'd0, obs_oe[14]}, 32'd0);
    chk("rd_ta1_value", {31'd0, obs_o[15]}, 32'd0);
    chk("rd_data", {16'd0, rd_word()}, 32'h7809);
    chk("rd_oe_window", {15'd0, oe_mask()}, 32'h1ffff);
    chk("rd_oe_released", {31'd0, mdio_oe}, 32'd0);

    // Write REG 0 = 2100
    c0 = n_cyc; o0 = oe_clks;
    send_frame(32, 2'b01, 5'd3, 5'd0, 16'h2100, 32);
    repeat (8) @(negedge clk);
    chk("wr_ncyc", n_cyc - c0, 1);
    chk("wr_we", {31'd0, last_we}, 32'd1);
    chk("wr_addr", {27'd0, last_addr}, 32'd0);
    chk("wr_data", {16'd0, last_dw}, 32'h2100);
    chk("wr_no_oe", oe_clks - o0, 0);

    // Frame to another PHY, then a good frame
    k0 = cyc_clks; o0 = oe_clks;
    send_frame(32, 2'b10, 5'd4, 5'd1, 16'h0, 32);
    chk("phy4_no_cyc", cyc_clks - k0, 0);
    chk("phy4_no_oe", oe_clks - o0, 0);
    data_read = 16'ha5c3;
    c0 = n_cyc;
    send_frame(32, 2'b10, 5'd3, 5'd2, 16'h0, 32);
    chk("after_phy4_ncyc", n_cyc - c0, 1);
    chk("after_phy4_addr", {27'd0, last_addr}, 32'd2);
    chk("after_phy4_data", {16'd0, rd_word()}, 32'ha5c3);

    // Read REG 9 with err response
    resp_mode = 1; c0 = n_cyc; o0 = oe_clks;
    send_frame(32, 2'b10, 5'd3, 5'd9, 16'h0, 32);
    chk("err_ncyc", n_cyc - c0, 1);
    chk("err_no_oe", oe_clks - o0, 0);
    resp_mode = 0;

    // Short preamble, then bad opcode
    k0 = cyc_clks;
    send_frame(31, 2'b10, 5'd3, 5'd1, 16'h0, 32);
    chk("short_pre_no_cyc", cyc_clks - k0, 0);
    k0 = cyc_clks;
    send_frame(32, 2'b11, 5'd3, 5'd1, 16'h0, 32);
    chk("op11_no_cyc", cyc_clks - k0, 0);

    // No response: aborted at TA0, MDIO never driven
    resp_mode = 2; c0 = n_cyc; o0 = oe_clks; k0 = cyc_clks;
    send_frame(32, 2'b10, 5'd3, 5'd5, 16'h0, 32);
    chk("abort_cyc_seen", {31'd0, (cyc_clks - k0) > 0}, 32'd1);
    chk("abort_no_oe", oe_clks - o0, 0);
    chk("abort_cyc_low", {31'd0, cyc}, 32'd0);

    // Reset while a read cycle is pending
    send_frame(32, 2'b10, 5'd3, 5'd6, 16'h0, 14);
    chk("pend_cyc_high", {31'd0, cyc}, 32'd1);
    #3 rst_n = 1'b0;
    #1 chk("pend_rst_cyc", {31'd0, cyc}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    resp_mode = 0;

    // Reset mid-DATA of a read, then a complete read
    data_read = 16'h7809;
    send_frame(32, 2'b10, 5'd3, 5'd1, 16'h0, 20);
    chk("mid_data_oe_high", {31'd0, mdio_oe}, 32'd1);
    #3 rst_n = 1'b0;
    #1 chk("mid_data_rst_oe", {31'd0, mdio_oe}, 32'd0);
    chk("mid_data_rst_cyc", {31'd0, cyc}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    data_read = 16'h1234;
    c0 = n_cyc;
    send_frame(32, 2'b10, 5'd3, 5'd7, 16'h0, 32);
    chk("post_rst_ncyc", n_cyc - c0, 1);
    chk("post_rst_addr", {27'd0, last_addr}, 32'd7);
    chk("post_rst_data", {16'd0, rd_word()}, 32'h1234);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
